// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU trace checker.
// Holds the 4-bit data width, the ALU opcode encoding and the checker FSM states.
package alu_chk_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU used by the trace checker to predict the result bus.
// All results wrap modulo 2**DATA_W. Divide by zero returns all ones and raises div0
// so the caller can decide whether the result is meaningful; opcode 7 yields zero.
module alu_ref_model
  import alu_chk_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              div0
);

  // Predict the ALU result for the current shadow operands.
  always_comb begin
    y    = '0;
    div0 = 1'b0;
    case (op_e'(op))
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = a * b;
      OP_DIV: begin
        if (b == '0) begin
          div0 = 1'b1;
          y    = '1;
        end else begin
          y = a / b;
        end
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_trace_checker.sv
// Trace checker for a small accumulator/counter ALU datapath.
// On start it mirrors the accumulator (shadow_w) and counter (shadow_b), compares the
// observed buses against them every step, and reports sticky error / first error step,
// a saturating error count and a timeout after MAX_STEPS tracked steps.
// Build option: define ALU_CHK_S_COMPARE_EN to also compare the observed ALU result
// s_in against the predicted result; otherwise s_in is ignored.
module alu_trace_checker
  import alu_chk_pkg::*;
#(
  parameter int MAX_STEPS = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] s_in,
  input  logic [2:0]        op_in,
  input  logic              cnt_in,
  input  logic              load_w_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [DATA_W-1:0] err_cnt,
  output logic [DATA_W-1:0] step_cnt,
  output logic [DATA_W-1:0] err_step
);

  localparam logic [DATA_W-1:0] TIMEOUT_STEP = DATA_W'(MAX_STEPS + 1);
  localparam logic [DATA_W-1:0] ERR_MAX      = '1;

  state_e            state;
  logic [DATA_W-1:0] shadow_w;
  logic [DATA_W-1:0] shadow_b;
  logic [DATA_W-1:0] cur_w;
  logic [DATA_W-1:0] cur_b;
  logic [DATA_W-1:0] exp_s;
  logic [DATA_W-1:0] step_nxt;
  logic [DATA_W-1:0] shadow_b_nxt;
  logic [DATA_W-1:0] shadow_w_nxt;
  logic              div0;
  logic              check_cyc;
  logic              last_cyc;
  logic              wb_bad;
  logic              op_bad;
  logic              s_bad;
  logic              err_now;

  // The start cycle is step 0 and is checked against freshly cleared shadows.
  always_comb begin
    cur_w = '0;
    cur_b = '0;
    if (state == S_TRACK) begin
      cur_w = shadow_w;
      cur_b = shadow_b;
    end
  end

  alu_ref_model u_ref (
    .a    (cur_w),
    .b    (cur_b),
    .op   (op_in),
    .y    (exp_s),
    .div0 (div0)
  );

`ifdef ALU_CHK_S_COMPARE_EN
  // A divide by zero has no defined result, so the result bus is not judged then.
  assign s_bad = (s_in != exp_s) && !div0;
`else
  logic s_cmp_unused;
  assign s_cmp_unused = ^{s_in, div0};
  assign s_bad        = 1'b0;
`endif

  // Classify this cycle: at most one error is counted no matter how many buses disagree.
  always_comb begin
    check_cyc    = ((state == S_IDLE) && start) || (state == S_TRACK);
    last_cyc     = (state == S_TRACK) && !cnt_in && !load_w_in;
    wb_bad       = (w_in != cur_w) || (b_in != cur_b);
    op_bad       = load_w_in && (op_in == 3'd7);
    err_now      = check_cyc && (wb_bad || (!last_cyc && (op_bad || s_bad)));
    step_nxt     = step_cnt + 1'b1;
    shadow_b_nxt = cur_b + {{(DATA_W-1){1'b0}}, cnt_in};
    shadow_w_nxt = load_w_in ? exp_s : cur_w;
  end

  // Control FSM: shadow tracking, step counting, end-of-trace and timeout detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shadow_w <= '0;
      shadow_b <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow_w <= shadow_w_nxt;
            shadow_b <= shadow_b_nxt;
            step_cnt <= DATA_W'(1);
            state    <= S_TRACK;
            busy     <= 1'b1;
          end
        end
        S_TRACK: begin
          if (last_cyc) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            shadow_w <= shadow_w_nxt;
            shadow_b <= shadow_b_nxt;
            step_cnt <= step_nxt;
            if (step_nxt == TIMEOUT_STEP) begin
              timeout <= 1'b1;
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Error bookkeeping: sticky flag, step of the first error, saturating count.
  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      err_step <= '0;
      err_cnt  <= '0;
    end else if (err_now) begin
      err <= 1'b1;
      if (!err) begin
        err_step <= step_cnt;
      end
      if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
